// File: rtl/grid_stream_pkg.sv
// Shared types and sizing helpers for the grid frame streamer.
package grid_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } top_state_e;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DONE   = 2'd1,
    ABORT  = 2'd2
  } ch_state_e;

  function automatic int ch_bits_f(input int grid_bits, input int channels);
    return grid_bits / channels;
  endfunction

  function automatic int nbytes_f(input int grid_bits, input int channels, input int byte_w);
    return (grid_bits / channels) / byte_w;
  endfunction

  // Byte index width; a single-byte slice still needs one bit of storage.
  function automatic int idx_w_f(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  // Timeout counter width; must hold the value TIMEOUT itself.
  function automatic int tmo_w_f(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/grid_frame_streamer_channel.sv
// One output channel: strobe synchroniser, edge detect, byte walker and stall timeout.
module grid_channel_tx
  import grid_stream_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int NBYTES      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NBYTES*BYTE_W-1:0] slice,
  input  logic                     strobe,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     error,
  output logic                     finished
);

  localparam int IW = idx_w_f(NBYTES);
  localparam int TW = tmo_w_f(TIMEOUT);

  logic [SYNC_STAGES-1:0]         sync_q;
  logic                           prev_q;
  logic                           edge_q;
  ch_state_e                      st_q, st_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [TW-1:0]                  tmo_q, tmo_d;
  logic                           err_q, err_d;
  logic [NBYTES-1:0][BYTE_W-1:0]  bytes;

  assign bytes = slice;

  // Bring the async strobe into the clock domain and register its rising edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  // Channel state, byte index, stall counter and sticky error.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st_q  <= DONE;
      idx_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  // Next state: accept restarts the walk; a strobe edge advances it; a stall aborts it.
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    tmo_d = tmo_q;
    err_d = err_q;
    if (start) begin
      st_d  = ACTIVE;
      idx_d = '0;
      tmo_d = '0;
      err_d = 1'b0;
    end else if (st_q == ACTIVE) begin
      if (edge_q) begin
        tmo_d = '0;
        if (idx_q == IW'(NBYTES - 1)) st_d = DONE;
        else                          idx_d = idx_q + 1'b1;
      end else if (TIMEOUT != 0) begin
        if (tmo_q == TW'(TIMEOUT)) begin
          st_d  = ABORT;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end
  end

  assign tx_start = (st_q == ACTIVE);
  assign tx_data  = (st_q == ACTIVE) ? bytes[idx_q] : '0;
  assign error    = err_q;
  assign finished = (st_q != ACTIVE);

endmodule

// File: rtl/grid_frame_streamer.sv
// Latches a grid frame and streams CHANNELS equal slices to strobe-paced display drivers.
module grid_frame_streamer
  import grid_stream_pkg::*;
#(
  parameter int GRID_BITS   = 256,
  parameter int CHANNELS    = 2,
  parameter int BYTE_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic [GRID_BITS-1:0]         frame_data,
  input  logic [CHANNELS-1:0]          ch_clk,
  output logic [CHANNELS-1:0]          ch_start,
  output logic [CHANNELS*BYTE_W-1:0]   ch_data,
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS-1:0]          ch_error,
  output logic [15:0]                  frame_count
);

  localparam int CH_BITS = ch_bits_f(GRID_BITS, CHANNELS);
  localparam int NBYTES  = nbytes_f(GRID_BITS, CHANNELS, BYTE_W);

  top_state_e           st_q, st_d;
  logic [GRID_BITS-1:0] frame_q;
  logic                 accept;
  logic [CHANNELS-1:0]  fin;

  assign accept = frame_valid & frame_ready;

  // Frame latch; only the accept cycle samples frame_data.
  always_ff @(posedge clock) begin
    if (accept) frame_q <= frame_data;
  end

  // Top state register and completed-frame counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st_q        <= IDLE;
      frame_count <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == SEND && (&fin)) frame_count <= frame_count + 16'd1;
    end
  end

  // Next state and handshake/status outputs.
  always_comb begin
    st_d        = st_q;
    frame_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (st_q)
      IDLE: begin
        frame_ready = reset_n;
        if (accept) st_d = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (&fin) st_d = FINISH;
      end
      FINISH: begin
        busy = 1'b1;
        done = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    grid_channel_tx #(
      .BYTE_W      (BYTE_W),
      .NBYTES      (NBYTES),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) u_tx (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (accept),
      .slice    (frame_q[c*CH_BITS +: CH_BITS]),
      .strobe   (ch_clk[c]),
      .tx_start (ch_start[c]),
      .tx_data  (ch_data[c*BYTE_W +: BYTE_W]),
      .error    (ch_error[c]),
      .finished (fin[c])
    );
  end

endmodule

// File: tb/tb_grid_frame_streamer.sv
// Randomised self-checking bench: a 2-channel instance (TIMEOUT=50) and a 4-channel instance (timeout off).
module tb_grid_frame_streamer;

  localparam int GB   = 256;
  localparam int SS   = 2;
  localparam int TMO  = 50;
  localparam int NB_A = GB / 2 / 8;
  localparam int NB_B = GB / 4 / 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic          a_valid, a_ready, a_busy, a_done;
  logic [GB-1:0] a_data;
  logic          a_stb [2];
  logic [1:0]    a_clk, a_start, a_err;
  logic [15:0]   a_chd, a_cnt;
  assign a_clk = {a_stb[1], a_stb[0]};

  logic          b_valid, b_ready, b_busy, b_done;
  logic [GB-1:0] b_data;
  logic          b_stb [4];
  logic [3:0]    b_clk, b_start, b_err;
  logic [31:0]   b_chd;
  logic [15:0]   b_cnt;
  assign b_clk = {b_stb[3], b_stb[2], b_stb[1], b_stb[0]};

  grid_frame_streamer #(.GRID_BITS(GB), .CHANNELS(2), .BYTE_W(8), .SYNC_STAGES(SS), .TIMEOUT(TMO)) u_a (
    .clock(clock), .reset_n(reset_n), .frame_valid(a_valid), .frame_ready(a_ready),
    .frame_data(a_data), .ch_clk(a_clk), .ch_start(a_start), .ch_data(a_chd),
    .busy(a_busy), .done(a_done), .ch_error(a_err), .frame_count(a_cnt));

  grid_frame_streamer #(.GRID_BITS(GB), .CHANNELS(4), .BYTE_W(8), .SYNC_STAGES(SS), .TIMEOUT(0)) u_b (
    .clock(clock), .reset_n(reset_n), .frame_valid(b_valid), .frame_ready(b_ready),
    .frame_data(b_data), .ch_clk(b_clk), .ch_start(b_start), .ch_data(b_chd),
    .busy(b_busy), .done(b_done), .ch_error(b_err), .frame_count(b_cnt));

  int errors = 0;
  int checks = 0;
  int a_dones = 0;
  int b_dones = 0;
  int exp_cnt_a = 0;

  // Count done pulses as sampled on each clock edge.
  always @(posedge clock) begin
    if (a_done === 1'b1) a_dones++;
    if (b_done === 1'b1) b_dones++;
  end

  // Reference: the frame is a flat run of bytes (byte 0 in the LSBs);
  // channel c owns the c-th contiguous block of GB/8/nch bytes.
  function automatic logic [7:0] exp_byte(input logic [GB-1:0] fr, input int nch, input int c, input int k);
    int per;
    logic [GB-1:0] sh;
    per = GB / 8 / nch;
    sh  = fr >> (8 * (c * per + k));
    return sh[7:0];
  endfunction

  function automatic logic [GB-1:0] rand_frame();
    logic [GB-1:0] f;
    for (int i = 0; i < GB / 32; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic strobe_a(input int c, input int k0, input int n, input int hi, input int lo,
                          input int skew, input logic [GB-1:0] fr);
    for (int k = k0; k < k0 + n; k++) begin
      @(negedge clock);
      checks++;
      if (a_start[c] !== 1'b1 || a_chd[c*8 +: 8] !== exp_byte(fr, 2, c, k)) begin
        errors++;
        $display("FAIL a_byte ch%0d k%0d: got start=%b data=%h, want start=1 data=%h",
                 c, k, a_start[c], a_chd[c*8 +: 8], exp_byte(fr, 2, c, k));
      end
      #(skew) a_stb[c] = 1'b1;
      repeat (hi) @(negedge clock);
      #(skew) a_stb[c] = 1'b0;
      repeat (lo) @(negedge clock);
    end
    if (k0 + n == NB_A) begin
      checks++;
      if (a_start[c] !== 1'b0 || a_chd[c*8 +: 8] !== 8'h00) begin
        errors++;
        $display("FAIL a_end ch%0d: got start=%b data=%h, want start=0 data=00", c, a_start[c], a_chd[c*8 +: 8]);
      end
    end
  endtask

  task automatic strobe_b(input int c, input int k0, input int n, input int skew, input logic [GB-1:0] fr);
    for (int k = k0; k < k0 + n; k++) begin
      @(negedge clock);
      checks++;
      if (b_start[c] !== 1'b1 || b_chd[c*8 +: 8] !== exp_byte(fr, 4, c, k)) begin
        errors++;
        $display("FAIL b_byte ch%0d k%0d: got start=%b data=%h, want start=1 data=%h",
                 c, k, b_start[c], b_chd[c*8 +: 8], exp_byte(fr, 4, c, k));
      end
      #(skew) b_stb[c] = 1'b1;
      repeat (5) @(negedge clock);
      #(skew) b_stb[c] = 1'b0;
      repeat (4) @(negedge clock);
    end
    if (k0 + n == NB_B) begin
      checks++;
      if (b_start[c] !== 1'b0 || b_chd[c*8 +: 8] !== 8'h00) begin
        errors++;
        $display("FAIL b_end ch%0d: got start=%b data=%h, want start=0 data=00", c, b_start[c], b_chd[c*8 +: 8]);
      end
    end
  endtask

  task automatic send_a(input logic [GB-1:0] fr);
    int n;
    n = 0;
    @(negedge clock);
    a_valid = 1'b1;
    a_data  = fr;
    while (a_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    a_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_start !== 2'b11 || a_chd !== {exp_byte(fr, 2, 1, 0), exp_byte(fr, 2, 0, 0)}) begin
      errors++;
      $display("FAIL a_accept: got busy=%b start=%b data=%h, want busy=1 start=11 data=%h",
               a_busy, a_start, a_chd, {exp_byte(fr, 2, 1, 0), exp_byte(fr, 2, 0, 0)});
    end
  endtask

  // Wait (bounded) until done has pulsed 'target' times in total, then check the counter.
  task automatic wait_frames_a(input int target, input int budget);
    int n;
    n = 0;
    while (a_dones < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (a_dones !== target || a_cnt !== 16'(exp_cnt_a)) begin
      errors++;
      $display("FAIL a_done: got dones=%0d count=%0d, want dones=%0d count=%0d", a_dones, a_cnt, target, exp_cnt_a);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data  = '0;   b_data  = '0;
    for (int i = 0; i < 2; i++) a_stb[i] = 1'b0;
    for (int i = 0; i < 4; i++) b_stb[i] = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset: got a=%b b=%b, want 0 0", a_ready, b_ready);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({a_ready, a_busy, a_done, a_start, a_err} !== 7'b1000000 || a_chd !== '0 || a_cnt !== '0) begin
      errors++;
      $display("FAIL a_reset_vals: got rdy=%b busy=%b done=%b start=%b err=%b data=%h cnt=%0d, want 1 0 0 00 00 0000 0",
               a_ready, a_busy, a_done, a_start, a_err, a_chd, a_cnt);
    end
    checks++;
    if ({b_ready, b_busy, b_done, b_start, b_err} !== 11'b100_0000_0000 || b_chd !== '0 || b_cnt !== '0) begin
      errors++;
      $display("FAIL b_reset_vals: got rdy=%b busy=%b done=%b start=%b err=%b data=%h cnt=%0d, want 1 0 0 0000 0000 0 0",
               b_ready, b_busy, b_done, b_start, b_err, b_chd, b_cnt);
    end
  endtask

  task automatic test_single();
    logic [GB-1:0] fr;
    int base;
    for (int i = 0; i < GB / 8; i++) fr[i*8 +: 8] = 8'(i);
    base = a_dones;
    send_a(fr);
    fork
      strobe_a(0, 0, NB_A, 5, 4, 0, fr);
      strobe_a(1, 0, NB_A, 5, 4, 3, fr);
    join
    exp_cnt_a++;
    wait_frames_a(base + 1, 50);
  endtask

  task automatic test_skew();
    logic [GB-1:0] fr;
    int base;
    fr   = rand_frame();
    base = a_dones;
    send_a(fr);
    fork
      begin
        strobe_a(0, 0, NB_A, 5, 4, 0, fr);
        checks++;
        if (a_start !== 2'b10 || a_dones !== base || a_busy !== 1'b1) begin
          errors++;
          $display("FAIL skew_order: got start=%b dones=%0d busy=%b, want start=10 dones=%0d busy=1",
                   a_start, a_dones, a_busy, base);
        end
      end
      strobe_a(1, 0, NB_A, 22, 20, 7, fr);
    join
    exp_cnt_a++;
    wait_frames_a(base + 1, 50);
  endtask

  task automatic test_timeout();
    logic [GB-1:0] fr;
    int base;
    fr   = rand_frame();
    base = a_dones;
    send_a(fr);
    fork
      strobe_a(0, 0, NB_A, 5, 4, 0, fr);
      begin
        strobe_a(1, 0, 4, 5, 4, 2, fr);
        checks++;
        if (a_err !== 2'b00 || a_start[1] !== 1'b1 || a_chd[15:8] !== exp_byte(fr, 2, 1, 4)) begin
          errors++;
          $display("FAIL tmo_stall: got err=%b start1=%b data1=%h, want err=00 start1=1 data1=%h",
                   a_err, a_start[1], a_chd[15:8], exp_byte(fr, 2, 1, 4));
        end
        repeat (38) @(negedge clock);
        checks++;
        if (a_err !== 2'b00) begin
          errors++;
          $display("FAIL tmo_early: got err=%b, want 00", a_err);
        end
        repeat (17) @(negedge clock);
        checks++;
        if (a_err !== 2'b10 || a_start[1] !== 1'b0 || a_start[0] !== 1'b1) begin
          errors++;
          $display("FAIL tmo_abort: got err=%b start=%b, want err=10 start=01", a_err, a_start);
        end
      end
    join
    exp_cnt_a++;
    wait_frames_a(base + 1, 50);
    checks++;
    if (a_err !== 2'b10) begin
      errors++;
      $display("FAIL tmo_sticky: got err=%b, want 10", a_err);
    end
    // Next accept clears the flags; with no strobes both channels then abort.
    fr = rand_frame();
    send_a(fr);
    checks++;
    if (a_err !== 2'b00) begin
      errors++;
      $display("FAIL tmo_clear: got err=%b, want 00", a_err);
    end
    exp_cnt_a++;
    wait_frames_a(base + 2, 120);
    checks++;
    if (a_err !== 2'b11 || a_start !== 2'b00) begin
      errors++;
      $display("FAIL tmo_both: got err=%b start=%b, want err=11 start=00", a_err, a_start);
    end
  endtask

  task automatic test_back_to_back();
    logic [GB-1:0] fx, fy;
    int base, n;
    fx   = rand_frame();
    fy   = rand_frame();
    base = a_dones;
    @(negedge clock);
    a_valid = 1'b1;
    a_data  = fx;
    n = 0;
    while (a_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    a_data = fy;
    fork
      strobe_a(0, 0, NB_A, 5, 4, 0, fx);
      strobe_a(1, 0, NB_A - 1, 5, 4, 1, fx);
    join
    @(negedge clock);
    checks++;
    if (a_chd[15:8] !== exp_byte(fx, 2, 1, NB_A - 1) || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last: got data1=%h rdy=%b, want data1=%h rdy=0", a_chd[15:8], a_ready, exp_byte(fx, 2, 1, NB_A - 1));
    end
    a_stb[1] = 1'b1;
    n = 0;
    while (a_done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 20 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got waited=%0d rdy=%b, want waited<20 rdy=0", n, a_ready);
    end
    @(negedge clock);
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got rdy=%b busy=%b, want 1 0", a_ready, a_busy);
    end
    @(negedge clock);
    a_stb[1] = 1'b0;
    a_valid  = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_start !== 2'b11 || a_chd !== {exp_byte(fy, 2, 1, 0), exp_byte(fy, 2, 0, 0)}) begin
      errors++;
      $display("FAIL b2b_accept2: got busy=%b start=%b data=%h, want 1 11 %h",
               a_busy, a_start, a_chd, {exp_byte(fy, 2, 1, 0), exp_byte(fy, 2, 0, 0)});
    end
    exp_cnt_a++;
    repeat (4) @(negedge clock);
    fork
      strobe_a(0, 0, NB_A, 5, 4, 0, fy);
      strobe_a(1, 0, NB_A, 6, 4, 4, fy);
    join
    exp_cnt_a++;
    wait_frames_a(base + 2, 50);
  endtask

  task automatic test_reset_mid();
    logic [GB-1:0] fr;
    int base;
    fr = rand_frame();
    send_a(fr);
    fork
      strobe_a(0, 0, 8, 5, 4, 0, fr);
      strobe_a(1, 0, 8, 5, 4, 2, fr);
    join
    base = a_dones;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    exp_cnt_a = 0;
    checks++;
    if ({a_ready, a_busy, a_done, a_start, a_err} !== 7'b0000000 || a_chd !== '0 || a_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b busy=%b done=%b start=%b err=%b data=%h cnt=%0d, want all 0",
               a_ready, a_busy, a_done, a_start, a_err, a_chd, a_cnt);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (a_dones !== base || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone: got dones=%0d busy=%b, want dones=%0d busy=0", a_dones, a_busy, base);
    end
    fr = rand_frame();
    send_a(fr);
    fork
      strobe_a(0, 0, NB_A, 5, 4, 0, fr);
      strobe_a(1, 0, NB_A, 5, 4, 3, fr);
    join
    exp_cnt_a++;
    wait_frames_a(base + 1, 50);
  endtask

  task automatic test_four_ch();
    logic [GB-1:0] fr;
    int base, n;
    force u_b.frame_count = 16'hFFFF;
    @(negedge clock);
    release u_b.frame_count;
    @(negedge clock);
    checks++;
    if (b_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL b_preset: got cnt=%h, want ffff", b_cnt);
    end
    fr   = rand_frame();
    base = b_dones;
    @(negedge clock);
    b_valid = 1'b1;
    b_data  = fr;
    @(negedge clock);
    b_valid = 1'b0;
    checks++;
    if (b_busy !== 1'b1 || b_start !== 4'b1111) begin
      errors++;
      $display("FAIL b_accept: got busy=%b start=%b, want 1 1111", b_busy, b_start);
    end
    fork
      strobe_b(0, 0, NB_B, 0, fr);
      strobe_b(1, 0, NB_B, 2, fr);
      strobe_b(2, 0, NB_B, 4, fr);
      begin
        strobe_b(3, 0, 4, 6, fr);
        repeat (120) @(negedge clock);
        checks++;
        if (b_err !== 4'b0000 || b_start[3] !== 1'b1) begin
          errors++;
          $display("FAIL b_no_timeout: got err=%b start3=%b, want 0000 1", b_err, b_start[3]);
        end
        strobe_b(3, 4, NB_B - 4, 6, fr);
      end
    join
    n = 0;
    while (b_dones < base + 1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (b_dones !== base + 1 || b_cnt !== 16'h0000 || b_err !== 4'b0000) begin
      errors++;
      $display("FAIL b_wrap: got dones=%0d cnt=%h err=%b, want dones=%0d cnt=0000 err=0000",
               b_dones, b_cnt, b_err, base + 1);
    end
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_skew();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_four_ch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
